uart_rx_oversampled: RTL
========================

Name: uart_rx_oversampled

Overview:
- Serial receiver; the receive end of the team's 8N1 async serial link.
- An internal prescaler derives an oversample tick from clk, the same timer scheme the transmit side uses.
- Start bit is validated at mid-bit, data bits are sampled at bit centres (LSB first), and the stop bit is checked.
- Delivers each received byte to the fabric with a one-cycle valid strobe; the whole block runs in the clk domain with no derived clocks.

Parameters:
- DATA_BITS, 8, data bits per frame (supported range 5..8).
- OVERSAMPLE, 16, ticks per bit period (even, >= 4).
- CLKS_PER_TICK, 16, clk cycles per oversample tick (>= 1); bit time = OVERSAMPLE*CLKS_PER_TICK clk.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx  in  1  serial line, asynchronous to clk, idle high
- rx_data  out  DATA_BITS  last good byte received, LSB = first bit received
- rx_valid  out  1  one-clk pulse when rx_data is updated
- frame_err  out  1  one-clk pulse when the stop bit is sampled low
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all of the following are cleared.
  - Outputs: rx_data=0, rx_valid=0, frame_err=0, busy=0.
  - Internal: state=IDLE, synchroniser flops=1, prescaler=0, tick count=0, bit count=0.
- Synchroniser: 2 flops on rx, giving rx_s; 2-clk input latency. All decisions use rx_s only.
- Prescaler: counts 0..CLKS_PER_TICK-1 and wraps.
  - tick is high for one clk when the count equals CLKS_PER_TICK-1.
  - Both counters are cleared on the clk in which IDLE detects rx_s=0, so sample phase is relative to the start edge.
- tcnt: 0..OVERSAMPLE-1, advances only on tick.
- State machine:
  - IDLE: when rx_s=0, go to START, clear tcnt, set busy.
  - START: on the tick where tcnt=OVERSAMPLE/2-1:
    - rx_s=0: clear tcnt, go to DATA, bit count=0.
    - rx_s=1: glitch; go to IDLE with no output pulse.
  - DATA: on the tick where tcnt=OVERSAMPLE-1, shift rx_s into the MSB of a shift register (right shift), clear tcnt, increment the bit count. After DATA_BITS samples, go to STOP.
  - STOP: on the tick where tcnt=OVERSAMPLE-1:
    - rx_s=1: rx_data<=shift register, rx_valid=1 for that clk, go to IDLE.
    - rx_s=0: frame_err=1 for that clk, rx_data unchanged, go to BRK_WAIT.
  - BRK_WAIT: stay until rx_s=1, then go to IDLE. A held-low break therefore produces exactly one frame_err and no retrigger.
- Latency: rx_valid asserts at the mid-stop sample. That is (1+DATA_BITS)*OVERSAMPLE*CLKS_PER_TICK + (OVERSAMPLE/2)*CLKS_PER_TICK clk after the synchronised falling edge, ±1 clk.
- Back-to-back frames: IDLE is re-entered at mid-stop, so a start edge half a bit after the stop centre is caught. No idle gap is required.
- rx_valid and frame_err are never high in the same clk.
- rx_data holds its value between frames; there is no consumer handshake and no overrun flag. The consumer must take the byte within one frame time.
- An rst assertion mid-frame aborts immediately. After release the block waits in IDLE for the next falling edge.

Decomposition:
- Shared package `serial_pkg`:
  - state encoding (IDLE, START, DATA, STOP, BRK_WAIT), 3 bits.
  - default DATA_BITS, OVERSAMPLE, CLKS_PER_TICK values, shared with the transmitter.
- One natural sub-module: `tick_gen`, a prescaler with sync clear, tick output and CLKS_PER_TICK parameter. It is reused by the transmitter.

Test Plan:
- Sim parameters for all scenarios: DATA_BITS=8, OVERSAMPLE=16, CLKS_PER_TICK=4, so bit time = 64 clk.
- Single frame 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1) -> exactly one rx_valid pulse with rx_data=0xA5. Pulse lands 608 clk ±3 after the rx falling edge; frame_err stays 0.
- Back-to-back 0x00 then 0xFF, no idle gap -> two rx_valid pulses 640 clk apart, rx_data=0x00 then 0xFF.
- 20-clk low glitch on an idle line -> no rx_valid and no frame_err; busy rises then falls within 40 clk. A following 0x3C frame is received correctly.
- Frame 0x55 with stop bit driven low, then the line held low for 2000 clk, then released -> exactly one frame_err pulse and rx_data keeps its previous value. busy stays high until the line is high, and a following 0x81 is received.
- rst asserted for 3 clk mid-way through the data bits of 0x12, then a clean 0x34 is sent -> all outputs 0 during reset, no pulse for the aborted frame, rx_valid with rx_data=0x34.
- Bit-time skew of ±3% (62 and 66 clk per bit) on frame 0xC3 -> rx_data=0xC3 in both cases, with no frame_err.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the 8N1 serial link (receiver and transmitter).
package serial_pkg;

  // Default frame and timing parameters for both link directions
  localparam int DEF_DATA_BITS     = 8;
  localparam int DEF_OVERSAMPLE    = 16;
  localparam int DEF_CLKS_PER_TICK = 16;

  // Receiver state encoding
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } rx_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-clk tick every CLKS_PER_TICK cycles.
// A synchronous clear restarts the count so tick phase can be aligned
// to an external event (the start edge on the receive side).
module tick_gen
  import serial_pkg::*;
#(
  parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_width(CLKS_PER_TICK);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] count;

  // Free-running 0..CLKS_PER_TICK-1 counter, restarted by clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr || count == LAST)
      count <= '0;
    else
      count <= count + 1'b1;
  end

  // A clear cycle never produces a tick so the new phase starts cleanly
  assign tick = (count == LAST) && !clr;

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling 8N1 serial receiver. The start edge re-phases the
// prescaler, the start bit is confirmed at mid-bit, data bits are taken
// at bit centres LSB first and the stop bit is checked at its centre.
module uart_rx_oversampled
  import serial_pkg::*;
#(
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int OVERSAMPLE    = DEF_OVERSAMPLE,
  parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = cnt_width(OVERSAMPLE);
  localparam int BW = cnt_width(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic                 tick;
  rx_state_t            state;
  rx_state_t            state_next;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;

  logic mid_hit;
  logic end_hit;
  logic start_det;
  logic tcnt_clr;
  logic do_shift;
  logic do_valid;
  logic do_err;

  assign mid_hit = tick && (tcnt == T_MID);
  assign end_hit = tick && (tcnt == T_LAST);

  // Two-flop synchroniser; line idles high so flops reset to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  tick_gen #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (start_det),
    .tick(tick)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (!rx_s) state_next = START;
      START:    if (mid_hit) state_next = rx_s ? IDLE : DATA;
      DATA:     if (end_hit && bcnt == B_LAST) state_next = STOP;
      STOP:     if (end_hit) state_next = rx_s ? IDLE : BRK_WAIT;
      BRK_WAIT: if (rx_s) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Per-state control strobes for the datapath
  always_comb begin
    start_det = 1'b0;
    tcnt_clr  = 1'b0;
    do_shift  = 1'b0;
    do_valid  = 1'b0;
    do_err    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  start_det = !rx_s;
      START: tcnt_clr  = mid_hit;
      DATA: begin
        do_shift = end_hit;
        tcnt_clr = end_hit;
      end
      STOP: begin
        do_valid = end_hit && rx_s;
        do_err   = end_hit && !rx_s;
      end
      default: ;
    endcase
  end

  // Oversample tick counter, phase-aligned to the start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tcnt <= '0;
    else if (start_det || tcnt_clr)
      tcnt <= '0;
    else if (tick)
      tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
  end

  // Data bit counter and LSB-first shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      shreg <= '0;
    end else if (start_det) begin
      bcnt <= '0;
    end else if (do_shift) begin
      bcnt  <= bcnt + 1'b1;
      shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end

  // Registered result: data and its strobe update in the same clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= do_valid;
      frame_err <= do_err;
      if (do_valid) rx_data <= shreg;
    end
  end

endmodule
